// File: rtl/bpsk_burst_tx.sv
// BPSK burst transmitter: frame buffer, command controller and carrier modulator in one block.
// Define BPSK_PREAMBLE_EN to send PREAMBLE before word 0 of every frame pass.
module bpsk_burst_tx #(
  parameter int unsigned           CLOCK_FRQ   = 12_000_000,
  parameter int unsigned           CARRIER_FRQ = 6_400,
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           DEPTH       = 16,
  parameter logic [DATA_WIDTH-1:0] PREAMBLE    = DATA_WIDTH'(8'hAA)
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_code,
  input  logic [1:0]              cyc_sel,
  output logic                    wave_out,
  output logic                    busy,
  output logic [1:0]              state_out,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    byte_done,
  output logic                    frame_done,
  output logic                    cmd_err
);

  localparam int unsigned HALF_DIV = CLOCK_FRQ / (2 * CARRIER_FRQ);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam int unsigned HW       = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int unsigned BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_DIV - 1);
  localparam logic [BW-1:0] BIT_MSB   = BW'(DATA_WIDTH - 1);
  localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TX    = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;
  localparam logic [1:0] ST_PRE   = 2'd3;

  localparam logic [1:0] CMD_ONCE  = 2'd0;
  localparam logic [1:0] CMD_LOOP  = 2'd1;
  localparam logic [1:0] CMD_STOP  = 2'd2;
  localparam logic [1:0] CMD_CLEAR = 2'd3;

`ifdef BPSK_PREAMBLE_EN
  localparam logic [1:0] ST_FIRST = ST_PRE;
`else
  localparam logic [1:0] ST_FIRST = ST_TX;
`endif

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic [HW-1:0] half_cnt_q, half_cnt_d;
  logic          phase_lo_q, phase_lo_d;
  logic [2:0]    cyc_cnt_q, cyc_cnt_d;
  logic [BW-1:0] bit_idx_q, bit_idx_d;
  logic [1:0]    cyc_lat_q, cyc_lat_d;
  logic          loop_q, loop_d;
  logic          stop_q, stop_d;
  logic          cmd_err_q, cmd_err_d;

  logic                  wr_fire, cmd_fire, sending;
  logic                  half_end, cycle_end, bit_end, word_end, last_word;
  logic [CW-1:0]         count_eff;
  logic [2:0]            cyc_max;
  logic [DATA_WIDTH-1:0] cur_word;
  logic                  cur_bit;
  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign wr_ready  = (state_q == ST_IDLE) && (count_q < DEPTH_CNT);
  assign cmd_ready = (state_q != ST_CLEAR);
  assign wr_fire   = wr_valid && wr_ready;
  assign cmd_fire  = cmd_valid && cmd_ready;
  // A write landing on the same edge as START is part of the frame.
  assign count_eff = count_q + CW'(wr_fire);
  assign sending   = (state_q == ST_TX) || (state_q == ST_PRE);

  always_comb begin
    case (cyc_lat_q)
      2'd0:    cyc_max = 3'd0;
      2'd1:    cyc_max = 3'd1;
      2'd2:    cyc_max = 3'd3;
      default: cyc_max = 3'd7;
    endcase
  end

  assign half_end  = (half_cnt_q == HALF_LAST);
  assign cycle_end = half_end && phase_lo_q;
  assign bit_end   = cycle_end && (cyc_cnt_q == cyc_max);
  assign word_end  = bit_end && (bit_idx_q == '0);
  assign last_word = ({1'b0, rd_ptr_q} == (count_q - CW'(1)));

  assign cur_word = (state_q == ST_PRE) ? PREAMBLE : mem[rd_ptr_q];
  assign cur_bit  = cur_word[bit_idx_q];

  // Carrier is high in the first half cycle; a 0 bit inverts it.
  assign wave_out   = sending && (cur_bit ? ~phase_lo_q : phase_lo_q);
  assign byte_done  = (state_q == ST_TX) && word_end;
  assign frame_done = byte_done && last_word;
  assign cmd_err    = cmd_err_q;
  assign busy       = (state_q != ST_IDLE);
  assign state_out  = state_q;
  assign count      = count_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    clr_ptr_d  = clr_ptr_q;
    half_cnt_d = half_cnt_q;
    phase_lo_d = phase_lo_q;
    cyc_cnt_d  = cyc_cnt_q;
    bit_idx_d  = bit_idx_q;
    cyc_lat_d  = cyc_lat_q;
    loop_d     = loop_q;
    stop_d     = stop_q;
    cmd_err_d  = 1'b0;

    // Counters wrap to their rest values on word_end, so IDLE always restarts cleanly.
    if (sending) begin
      half_cnt_d = half_end ? '0 : half_cnt_q + HW'(1);
      if (half_end)  phase_lo_d = ~phase_lo_q;
      if (cycle_end) cyc_cnt_d = bit_end ? 3'd0 : cyc_cnt_q + 3'd1;
      if (bit_end)   bit_idx_d = word_end ? BIT_MSB : bit_idx_q - BW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (wr_fire) count_d = count_q + CW'(1);
        if (cmd_fire) begin
          case (cmd_code)
            CMD_ONCE, CMD_LOOP: begin
              if (count_eff == '0) begin
                cmd_err_d = 1'b1;
              end else begin
                state_d   = ST_FIRST;
                cyc_lat_d = cyc_sel;
                loop_d    = (cmd_code == CMD_LOOP);
                stop_d    = 1'b0;
                rd_ptr_d  = '0;
              end
            end
            CMD_CLEAR: begin
              state_d   = ST_CLEAR;
              clr_ptr_d = '0;
            end
            default: ;
          endcase
        end
      end
      ST_TX, ST_PRE: begin
        if (cmd_fire) begin
          if (cmd_code == CMD_STOP) stop_d = 1'b1;
          else cmd_err_d = 1'b1;
        end
        if (word_end) begin
          if (state_q == ST_PRE) begin
            state_d = stop_q ? ST_IDLE : ST_TX;
            if (stop_q) stop_d = 1'b0;
          end else if (stop_q || (last_word && !loop_q)) begin
            state_d  = ST_IDLE;
            stop_d   = 1'b0;
            rd_ptr_d = '0;
          end else if (last_word) begin
            state_d  = ST_FIRST;
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
      end
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == PTR_LAST) begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      clr_ptr_q  <= '0;
      half_cnt_q <= '0;
      phase_lo_q <= 1'b0;
      cyc_cnt_q  <= 3'd0;
      bit_idx_q  <= BIT_MSB;
      cyc_lat_q  <= 2'd0;
      loop_q     <= 1'b0;
      stop_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      clr_ptr_q  <= clr_ptr_d;
      half_cnt_q <= half_cnt_d;
      phase_lo_q <= phase_lo_d;
      cyc_cnt_q  <= cyc_cnt_d;
      bit_idx_q  <= bit_idx_d;
      cyc_lat_q  <= cyc_lat_d;
      loop_q     <= loop_d;
      stop_q     <= stop_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  // Loads only happen in IDLE and zeroing only in CLEAR, so one write port suffices.
  assign mem_we    = wr_fire || (state_q == ST_CLEAR);
  assign mem_waddr = (state_q == ST_CLEAR) ? clr_ptr_q : count_q[AW-1:0];
  assign mem_wdata = (state_q == ST_CLEAR) ? '0 : wr_data;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule
